// File: rtl/trigger_ctrl.sv
// -----------------------------------------------------------------------------
// trigger_ctrl
//   Turns a raw push-button pin into a clean, fixed-length `trigger` level that
//   is hard-wired into register x5, so software sees x5 = 1 once per press.
//   The button is synchronised, the press is debounced, trigger is held for
//   HOLD_CYCLES, and the block re-arms only after a debounced release.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   btn_in       raw asynchronous button level, 1 = pressed
//   trigger      high only while the state is ACTIVE
//   armed        high while the state is IDLE (ready for a new press)
//   press_count  accepted presses, wraps modulo 256
// -----------------------------------------------------------------------------
module trigger_ctrl #(
  parameter int DB_CYCLES   = 16,
  parameter int HOLD_CYCLES = 64,
  parameter int CNT_WIDTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       trigger,
  output logic       armed,
  output logic [7:0] press_count
);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    ACTIVE,
    WAIT_REL,
    DB_REL
  } state_e;

  localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DB_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           press_count_q, press_count_d;

  logic btn_s;
  assign btn_s = sync2_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    sync1_d       = btn_in;
    sync2_d       = sync1_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    press_count_d = press_count_q;

    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end

      DB_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;         // bounce rejected
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d       = ACTIVE;
          cnt_d         = '0;
          press_count_d = press_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Button is deliberately ignored here so the pulse always runs its full
      // length regardless of release or bounce.
      ACTIVE: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_REL: begin
        if (!btn_s) begin
          state_d = DB_REL;
          cnt_d   = '0;
        end
      end

      DB_REL: begin
        if (btn_s) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: reset is synchronous; rst_n is only seen at a rising clk edge.
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      press_count_q <= 8'd0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      press_count_q <= press_count_d;
    end
  end

  // Pure decodes of registered state: glitch-free, change only after edges.
  assign trigger     = (state_q == ACTIVE);
  assign armed       = (state_q == IDLE);
  assign press_count = press_count_q;

endmodule

// File: doc/trigger_ctrl.md
Name: trigger_ctrl

Overview:
- Generates the `trigger` level consumed by the register file: a 1-bit value hard-wired into register x5.
- Sits between a raw, asynchronous push-button pin and the CPU top level.
- Synchronises and debounces the button, then asserts `trigger` for a fixed number of cycles, so the running program sees x5 = 1 exactly once per press.
- Re-arms only after a debounced release, and counts accepted presses for debug or display.

Parameters:
- DB_CYCLES, 16: consecutive stable cycles needed to accept a press or a release (must be ≥ 1).
- HOLD_CYCLES, 64: number of cycles `trigger` stays high per accepted press (must be ≥ 1).
- CNT_WIDTH, 8: width of the internal timing counter; must satisfy 2^CNT_WIDTH ≥ max(DB_CYCLES, HOLD_CYCLES).

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- btn_in  input  1  raw asynchronous button level, 1 = pressed.
- trigger  output  1  drives register file x5; high only while the state is ACTIVE.
- armed  output  1  high while the state is IDLE (ready for a new press).
- press_count  output  8  number of accepted presses, wraps modulo 256.

Behaviour:
- Clock and reset
  - One clock (`clk`).
  - Reset is synchronous and active-low: `rst_n` is sampled on the rising edge of `clk`.
  - While `rst_n` = 0 at an edge: state ← IDLE, counter ← 0, both synchroniser flops ← 0, press_count ← 0.
  - Output values after reset: trigger = 0, armed = 1, press_count = 0.
  - Reset asserted mid-operation, including during ACTIVE, drops `trigger` in the cycle after that edge; there is no partial completion.
- Synchroniser
  - Two flops: sync1 ← btn_in, sync2 ← sync1.
  - `btn_s` = sync2. Only `btn_s` feeds the FSM.
- States: IDLE, DB_PRESS, ACTIVE, WAIT_REL, DB_REL. Counter `cnt` is CNT_WIDTH bits.
- IDLE
  - btn_s = 1 → DB_PRESS, cnt ← 0.
  - Otherwise stay.
- DB_PRESS
  - btn_s = 0 → IDLE (bounce rejected), cnt ← 0.
  - btn_s = 1 and cnt = DB_CYCLES−1 → ACTIVE, cnt ← 0, press_count ← press_count + 1.
  - Otherwise cnt ← cnt + 1.
- ACTIVE
  - trigger = 1.
  - Button state is ignored: release or bounce does not shorten the pulse.
  - cnt = HOLD_CYCLES−1 → WAIT_REL, cnt ← 0.
  - Otherwise cnt ← cnt + 1.
  - Result: trigger is high for exactly HOLD_CYCLES consecutive cycles.
- WAIT_REL
  - btn_s = 0 → DB_REL, cnt ← 0.
  - Holding the button does not retrigger.
- DB_REL
  - btn_s = 1 → WAIT_REL, cnt ← 0.
  - btn_s = 0 and cnt = DB_CYCLES−1 → IDLE, cnt ← 0.
  - Otherwise cnt ← cnt + 1.
- Outputs
  - trigger and armed are pure decodes of the registered state, so they are glitch-free and change only after clock edges.
- Latency
  - btn_in high, first sampled at edge k → btn_s = 1 after edge k+1 → DB_PRESS after edge k+2.
  - ACTIVE (trigger = 1) after edge k+2+DB_CYCLES, if the button stays stable throughout.
- press_count wraps 255 → 0 with no flag.
- DB_CYCLES = 1 is legal: a press is accepted after a single stable cycle in DB_PRESS.
- cnt never exceeds max(DB_CYCLES, HOLD_CYCLES)−1.

Test Plan (bench parameters DB_CYCLES = 4, HOLD_CYCLES = 8):
- Reset: hold rst_n = 0 for 3 edges with btn_in = 1 → trigger = 0, armed = 1, press_count = 0 throughout. After release, trigger rises 2 + 4 edges later.
- Clean press: btn_in 0→1 first sampled at edge 10, held high → trigger = 1 after edge 16, for exactly 8 cycles. press_count = 1. armed = 0 from the edge-12 update until the release debounce completes.
- Bounce rejection: btn_in high for 2 cycles, low for 1, high for 2, then low → trigger never asserts, press_count stays 0, FSM returns to IDLE.
- Release during pulse and no retrigger:
  - Release 2 cycles into ACTIVE → trigger still lasts 8 cycles.
  - Holding the button for 100 cycles → exactly one 8-cycle pulse, press_count increments by 1 only.
- Re-arm: press, release, then release bounce (0 for 2, 1 for 1, 0 stable) → stays out of IDLE until 4 stable low cycles. A second press then yields a second pulse and press_count = 2.
- Reset mid-pulse and wrap:
  - rst_n = 0 at cycle 3 of ACTIVE → trigger = 0 after that edge, press_count = 0.
  - 256 accepted presses → press_count wraps to 0.
